// File: rtl/exec_controller_pkg.sv
// Shared types for the run-control sequencer: run state and instruction-source encodings.
package exec_ctrl_pkg;

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    AUTO   = 2'd1,
    LOAD   = 2'd2
  } exec_state_t;

  localparam logic INSTR_SRC_ROM = 1'b0;
  localparam logic INSTR_SRC_SW  = 1'b1;

endpackage

// File: rtl/exec_controller_rise_pulse.sv
// Rising-edge detector for a debounced level. History resets to 1 so a held button yields no edge.
module rise_pulse (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  logic btn_q;

  always_ff @(posedge clk) begin
    if (reset) btn_q <= 1'b1;
    else       btn_q <= btn;
  end

  assign rise = btn & ~btn_q;

endmodule

// File: rtl/exec_controller.sv
// Run-control sequencer: manual step / auto run CPU strobe, instruction source select, ROM load.
// Optional macro EXEC_HALT_DETECT_EN adds pc self-jump detection with a sticky halted flag.
module exec_controller
  import exec_ctrl_pkg::*;
#(
  parameter int AUTO_DIV = 25_000_000,
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode_btn,
  input  logic              step_btn,
  input  logic              initialize,
  input  logic [DATA_W-1:0] switches,
  output logic              cpu_en,
  output logic              cpu_reset,
  output logic              instr_sel,
  output logic              load_we,
  output logic [ADDR_W-1:0] load_addr,
  output logic [DATA_W-1:0] load_data,
  output logic              auto_led
`ifdef EXEC_HALT_DETECT_EN
  ,
  input  logic [ADDR_W-1:0] pc,
  output logic              halted
`endif
);

  localparam int CNT_W = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(AUTO_DIV - 1);

  exec_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_d;
  logic              en_d, we_d;
  logic              mode_rise, step_rise;
  logic              halt_hit;

  rise_pulse u_mode_rise (.clk(clk), .reset(reset), .btn(mode_btn), .rise(mode_rise));
  rise_pulse u_step_rise (.clk(clk), .reset(reset), .btn(step_btn), .rise(step_rise));

`ifdef EXEC_HALT_DETECT_EN
  logic [ADDR_W-1:0] pc_q;
  logic              chk_q;

  // pc_q holds the pc seen during the strobe; one cycle later the CPU has advanced.
  assign halt_hit = chk_q && (state_q == AUTO) && (pc == pc_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= '0;
      chk_q  <= 1'b0;
      halted <= 1'b0;
    end else begin
      chk_q <= cpu_en && (state_q == AUTO);
      if (cpu_en) pc_q <= pc;
      if (halt_hit)       halted <= 1'b1;
      else if (mode_rise) halted <= 1'b0;
    end
  end
`else
  assign halt_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    en_d    = 1'b0;
    we_d    = 1'b0;
    cnt_d   = '0;
    addr_d  = load_addr;
    case (state_q)
      MANUAL: begin
        if (mode_rise)      state_d = AUTO;
        else if (step_rise) en_d    = 1'b1;
      end
      AUTO: begin
        if (mode_rise || halt_hit) begin
          state_d = MANUAL;
        end else if (cnt_q == DIV_LAST) begin
          en_d  = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOAD: begin
        if (!initialize)    state_d = MANUAL;
        else if (step_rise) we_d    = 1'b1;
      end
      default: state_d = MANUAL;
    endcase
    // The write address advances the cycle after each write strobe.
    if (load_we) addr_d = load_addr + 1'b1;
    if (initialize) begin
      state_d = LOAD;
      en_d    = 1'b0;
      cnt_d   = '0;
      if (state_q != LOAD) addr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= MANUAL;
      cnt_q     <= '0;
      cpu_en    <= 1'b0;
      load_we   <= 1'b0;
      load_addr <= '0;
      load_data <= '0;
      cpu_reset <= 1'b1;
      instr_sel <= INSTR_SRC_SW;
      auto_led  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cpu_en    <= en_d;
      load_we   <= we_d;
      load_addr <= addr_d;
      if (we_d) load_data <= switches;
      cpu_reset <= (state_d == LOAD);
      instr_sel <= (state_d == AUTO) ? INSTR_SRC_ROM : INSTR_SRC_SW;
      auto_led  <= (state_d == AUTO);
    end
  end

endmodule

// File: tb/tb_exec_controller.sv
// Bench for exec_controller: strobe cycles and load writes are collected by a monitor and
// compared against expectations computed from press cycles with plain arithmetic.
module tb_exec_controller;

  localparam int AUTO_DIV = 10;
  localparam int ADDR_W   = 2;
  localparam int DATA_W   = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              mode_btn = 1'b0;
  logic              step_btn = 1'b0;
  logic              initialize = 1'b0;
  logic [DATA_W-1:0] switches = '0;
  logic              cpu_en, cpu_reset, instr_sel, load_we, auto_led;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
`ifdef EXEC_HALT_DETECT_EN
  logic [ADDR_W-1:0] pc;
  logic              halted;
  logic              pc_freeze = 1'b0;
`endif

  typedef struct packed {
    logic [31:0]       cyc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } load_ev_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int overlap = 0;
  logic [31:0] en_q[$];
  logic [31:0] exp_q[$];
  load_ev_t    ld_q[$];
  load_ev_t    exp_ld_q[$];

  exec_controller #(.AUTO_DIV(AUTO_DIV), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .mode_btn(mode_btn), .step_btn(step_btn),
    .initialize(initialize), .switches(switches), .cpu_en(cpu_en), .cpu_reset(cpu_reset),
    .instr_sel(instr_sel), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .auto_led(auto_led)
`ifdef EXEC_HALT_DETECT_EN
    , .pc(pc), .halted(halted)
`endif
  );

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef EXEC_HALT_DETECT_EN
  // CPU stand-in: pc advances on every strobe unless frozen in a self-jump.
  always @(posedge clk) begin
    if (reset) pc <= '0;
    else if (cpu_en && !pc_freeze) pc <= pc + 1'b1;
  end
`endif

  // monitor
  always @(negedge clk) begin
    load_ev_t ev;
    if (cpu_en === 1'b1) en_q.push_back(32'(cyc));
    if (load_we === 1'b1) begin
      ev.cyc = 32'(cyc); ev.addr = load_addr; ev.data = load_data;
      ld_q.push_back(ev);
    end
    if (cpu_en === 1'b1 && load_we === 1'b1) overlap++;
  end

  // driver: advance n cycles and land just after the active edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step_btn = 1'b1;
    tick(3);
    @(negedge clk);
    checks++; if (cpu_reset !== 1'b1) begin failures++; $display("FAIL rst_cpu_reset: got %b want 1", cpu_reset); end
    checks++; if ({cpu_en, load_we, auto_led} !== 3'b000) begin failures++; $display("FAIL rst_strobes: got %b want 000", {cpu_en, load_we, auto_led}); end
    checks++; if (instr_sel !== 1'b1) begin failures++; $display("FAIL rst_instr_sel: got %b want 1", instr_sel); end
    checks++; if ({load_addr, load_data} !== '0) begin failures++; $display("FAIL rst_load_regs: got %h/%h want 0/0", load_addr, load_data); end
    tick(1);
    en_q.delete();
    reset = 1'b0;
    tick(1);
    @(negedge clk);
    checks++; if (cpu_reset !== 1'b0) begin failures++; $display("FAIL rel_cpu_reset: got %b want 0", cpu_reset); end
    tick(5);
    checks++; if (en_q.size() !== 0) begin failures++; $display("FAIL held_step_no_en: got %0d pulses want 0", en_q.size()); end
    checks++; if (instr_sel !== 1'b1) begin failures++; $display("FAIL rel_instr_sel: got %b want 1", instr_sel); end
    step_btn = 1'b0;
    tick(3);
  endtask

  task automatic test_manual_steps(input int presses, input int max_hold);
    en_q.delete(); exp_q.delete();
    for (int i = 0; i < presses; i++) begin
      step_btn = 1'b1;
      switches = DATA_W'($urandom);
      exp_q.push_back(32'(cyc + 1));
      tick((max_hold == 20) ? 20 : int'($urandom_range(1, max_hold)));
      step_btn = 1'b0;
      tick($urandom_range(1, 6));
    end
    tick(3);
    checks++;
    if (en_q.size() !== exp_q.size()) begin
      failures++; $display("FAIL manual_count: got %0d want %0d", en_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (en_q[i] !== exp_q[i]) begin failures++; $display("FAIL manual_cycle[%0d]: got %0d want %0d", i, en_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_auto();
    int n, m, run;
    en_q.delete(); exp_q.delete();
    mode_btn = 1'b1; n = cyc;
    tick(3); mode_btn = 1'b0;
    step_btn = 1'b1; tick(2); step_btn = 1'b0;
    run = 100 + int'($urandom_range(0, 9));
    tick(n + 1 + run - cyc);
    @(negedge clk);
    checks++; if (auto_led !== 1'b1) begin failures++; $display("FAIL auto_led: got %b want 1", auto_led); end
    checks++; if (instr_sel !== 1'b0) begin failures++; $display("FAIL auto_instr_sel: got %b want 0", instr_sel); end
    tick(1);
    m = cyc; mode_btn = 1'b1;
    for (int k = 1; n + 1 + k * AUTO_DIV <= m; k++) exp_q.push_back(32'(n + 1 + k * AUTO_DIV));
    tick(3); mode_btn = 1'b0;
    tick(30);
    @(negedge clk);
    checks++; if ({auto_led, instr_sel} !== 2'b01) begin failures++; $display("FAIL auto_exit: got led/sel %b want 01", {auto_led, instr_sel}); end
    checks++;
    if (en_q.size() !== exp_q.size()) begin
      failures++; $display("FAIL auto_count: got %0d want %0d", en_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (en_q[i] !== exp_q[i]) begin failures++; $display("FAIL auto_cycle[%0d]: got %0d want %0d", i, en_q[i], exp_q[i]); end
      end
    end
    tick(1);
  endtask

  task automatic test_load();
    logic [DATA_W-1:0] data_tbl [5];
    logic [DATA_W-1:0] w;
    load_ev_t ev;
    int bad_rst = 0;
    data_tbl[0] = 16'h000F; data_tbl[1] = 16'hEC10; data_tbl[2] = 16'h0002;
    data_tbl[3] = DATA_W'($urandom); data_tbl[4] = DATA_W'($urandom);
    ld_q.delete(); exp_ld_q.delete(); en_q.delete();
    initialize = 1'b1;
    tick(2);
    mode_btn = 1'b1; tick(2); mode_btn = 1'b0; tick(1);
    for (int i = 0; i < 5; i++) begin
      w = data_tbl[i];
      switches = w; step_btn = 1'b1;
      ev.cyc = 32'(cyc + 1); ev.addr = ADDR_W'(i); ev.data = w;
      exp_ld_q.push_back(ev);
      tick($urandom_range(1, 5));
      step_btn = 1'b0; switches = DATA_W'($urandom);
      @(negedge clk);
      if (cpu_reset !== 1'b1) bad_rst++;
      tick($urandom_range(2, 4));
    end
    checks++; if (bad_rst !== 0) begin failures++; $display("FAIL load_cpu_reset: got %0d low samples want 0", bad_rst); end
    checks++;
    if (ld_q.size() !== exp_ld_q.size()) begin
      failures++; $display("FAIL load_count: got %0d want %0d", ld_q.size(), exp_ld_q.size());
    end else begin
      for (int i = 0; i < exp_ld_q.size(); i++) begin
        checks++;
        if (ld_q[i] !== exp_ld_q[i])
          begin failures++; $display("FAIL load_write[%0d]: got cyc %0d addr %0d data %h want cyc %0d addr %0d data %h",
                            i, ld_q[i].cyc, ld_q[i].addr, ld_q[i].data, exp_ld_q[i].cyc, exp_ld_q[i].addr, exp_ld_q[i].data); end
      end
    end
    initialize = 1'b0;
    tick(1);
    @(negedge clk);
    checks++; if (cpu_reset !== 1'b0) begin failures++; $display("FAIL load_exit_cpu_reset: got %b want 0", cpu_reset); end
    checks++; if (load_addr !== ADDR_W'(5 % (1 << ADDR_W))) begin failures++; $display("FAIL load_final_addr: got %0d want %0d", load_addr, 5 % (1 << ADDR_W)); end
    checks++; if ({auto_led, en_q.size() == 0} !== 2'b01) begin failures++; $display("FAIL load_mode_ignored: got led %b pulses %0d want 0 and 0", auto_led, en_q.size()); end
    tick(2);
  endtask

  task automatic test_simultaneous();
    int n, m;
    en_q.delete(); exp_q.delete();
    mode_btn = 1'b1; step_btn = 1'b1; n = cyc;
    tick(1);
    @(negedge clk);
    checks++; if ({cpu_en, auto_led} !== 2'b01) begin failures++; $display("FAIL simul_mode_wins: got en/led %b want 01", {cpu_en, auto_led}); end
    tick(1); mode_btn = 1'b0; step_btn = 1'b0;
    tick(n + 25 - cyc);
    m = cyc; mode_btn = 1'b1;
    for (int k = 1; n + 1 + k * AUTO_DIV <= m; k++) exp_q.push_back(32'(n + 1 + k * AUTO_DIV));
    tick(2); mode_btn = 1'b0; tick(5);
    checks++;
    if (en_q.size() !== exp_q.size()) begin
      failures++; $display("FAIL simul_count: got %0d want %0d", en_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (en_q[i] !== exp_q[i]) begin failures++; $display("FAIL simul_cycle[%0d]: got %0d want %0d", i, en_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    en_q.delete(); ld_q.delete();
    mode_btn = 1'b1; n = cyc;
    tick(2); mode_btn = 1'b0;
    tick(n + AUTO_DIV - cyc);
    reset = 1'b1;
    tick(1);
    @(negedge clk);
    checks++; if ({cpu_en, auto_led, instr_sel, cpu_reset} !== 4'b0011) begin failures++; $display("FAIL auto_reset: got en/led/sel/rst %b want 0011", {cpu_en, auto_led, instr_sel, cpu_reset}); end
    tick(1); reset = 1'b0; tick(3);
    checks++; if (en_q.size() !== 0) begin failures++; $display("FAIL auto_reset_cancel: got %0d pulses want 0", en_q.size()); end
    initialize = 1'b1;
    tick(2);
    step_btn = 1'b1; reset = 1'b1;
    tick(1);
    @(negedge clk);
    checks++; if ({load_we, load_addr, cpu_reset} !== {1'b0, {ADDR_W{1'b0}}, 1'b1}) begin failures++; $display("FAIL load_reset: got we %b addr %0d rst %b want 0 0 1", load_we, load_addr, cpu_reset); end
    tick(1); initialize = 1'b0; reset = 1'b0; tick(3);
    checks++; if ({ld_q.size() == 0, en_q.size() == 0, cpu_reset} !== 3'b110) begin failures++; $display("FAIL load_reset_cancel: got writes %0d pulses %0d rst %b want 0 0 0", ld_q.size(), en_q.size(), cpu_reset); end
    step_btn = 1'b0; tick(2);
  endtask

`ifdef EXEC_HALT_DETECT_EN
  task automatic test_halt();
    int n;
    en_q.delete();
    pc_freeze = 1'b1;
    mode_btn = 1'b1; n = cyc;
    tick(2); mode_btn = 1'b0;
    tick(n + 12 - cyc);
    @(negedge clk);
    checks++; if ({auto_led, halted} !== 2'b10) begin failures++; $display("FAIL halt_pre: got led/halted %b want 10", {auto_led, halted}); end
    tick(1);
    @(negedge clk);
    checks++; if ({auto_led, halted, instr_sel} !== 3'b011) begin failures++; $display("FAIL halt_forced: got led/halted/sel %b want 011", {auto_led, halted, instr_sel}); end
    checks++; if (en_q.size() !== 1 || en_q[0] !== 32'(n + 11)) begin failures++; $display("FAIL halt_pulses: got %0d pulses want 1 at %0d", en_q.size(), n + 11); end
    pc_freeze = 1'b0;
    tick(1); mode_btn = 1'b1; tick(1);
    @(negedge clk);
    checks++; if ({auto_led, halted} !== 2'b10) begin failures++; $display("FAIL halt_clear: got led/halted %b want 10", {auto_led, halted}); end
    tick(1); mode_btn = 1'b0; tick(3);
    mode_btn = 1'b1; tick(2); mode_btn = 1'b0; tick(3);
  endtask
`endif

  initial begin
    test_reset();
    test_manual_steps(4, 20);
    test_manual_steps(8, 15);
    test_auto();
    test_load();
    test_simultaneous();
    test_reset_mid_run();
`ifdef EXEC_HALT_DETECT_EN
    test_halt();
`endif
    checks++; if (overlap !== 0) begin failures++; $display("FAIL en_we_overlap: got %0d cycles want 0", overlap); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
